apb_cmd_queue: RTL and testbench
================================

APB_CMD_QUEUE -- requirements
Module: apb_cmd_queue

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 Parameter DEPTH, default 4: entries per FIFO (command and response); power of 2, minimum 2.
REQ-003 Parameter TMO_CYC, default 256: watchdog limit in cycles; used only with APB_CMDQ_TIMEOUT_EN.
REQ-004 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted on clk edge when both valid and ready are high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed on clk edge when both valid and ready are high
- rsp_write  out  1  echo of the command's write bit
- rsp_addr  out  32  echo of the command's address
- rsp_rdata  out  32  read data (0 for writes)
- rsp_err  out  1  transfer aborted
- req  out  1  request to apb_master
- write  out  1  direction to apb_master
- addr  out  32  address to apb_master
- wdata  out  32  data to apb_master
- rdata  in  32  read data from apb_master
- ready  in  1  transfer complete from apb_master
- cmd_count  out  $clog2(DEPTH)+1  command FIFO occupancy

Function
REQ-005 The command FIFO SHALL store {write, addr, wdata} and be DEPTH deep.
REQ-006 cmd_ready SHALL be high if and only if the registered command count is less than DEPTH.
- When the FIFO is full, an issue-side pop in the same cycle SHALL NOT raise cmd_ready in that cycle.
REQ-007 The FSM SHALL have three states: IDLE, REQ and GAP.
REQ-008 IDLE -> REQ SHALL occur when the command FIFO is non-empty and the response FIFO occupancy plus in-flight transfers is less than DEPTH.
- This reserves the response slot at issue time, so the response FIFO never overflows.
REQ-009 In REQ:
- req=1 SHALL be registered.
- write, addr and wdata SHALL be driven from the FIFO head and held stable until exit.
REQ-010 REQ -> GAP SHALL occur on the clk edge where ready=1. On that edge the block SHALL:
- pop the command;
- push {write, addr, write?0:rdata, err=0} into the response FIFO.
REQ-011 GAP SHALL drive req=0 for exactly one cycle, then go to IDLE.
- Back-to-back commands SHALL therefore be separated by at least one req-low cycle.
REQ-012 Latency: a command accepted at edge T0 into an empty queue and idle FSM SHALL drive req=1 from edge T0+1.
REQ-013 Latency: a response pushed at edge T1 SHALL show rsp_valid=1 from edge T1.
REQ-014 ready=1 while in IDLE or GAP SHALL be ignored.
REQ-015 The response FIFO SHALL present its head on the rsp_* outputs, with rsp_valid = not empty.
- A simultaneous push and pop when full SHALL be legal and leave occupancy unchanged.
REQ-016 Both FIFOs SHALL wrap read and write pointers modulo DEPTH.
- Full and empty SHALL be derived from a count or an extra pointer bit, never from pointer equality alone.
REQ-017 Commands SHALL be issued and responses returned strictly in acceptance order.

Reset
REQ-018 When rst is asserted, all of the following SHALL be cleared asynchronously:
- FSM = IDLE;
- both FIFOs empty;
- cmd_count=0;
- req=0, write=0, addr=0, wdata=0;
- rsp_valid=0, rsp_write=0, rsp_addr=0, rsp_rdata=0, rsp_err=0;
- cmd_ready=0 while rst=1.
REQ-019 rst asserted mid-transfer SHALL abandon the in-flight command with no response generated.
REQ-020 cmd_ready SHALL rise on the first clk edge after rst deasserts.

Configuration
REQ-021 Macro APB_CMDQ_TIMEOUT_EN, when defined, SHALL add a watchdog cleared on REQ entry and incremented each cycle in REQ.
- If it reaches TMO_CYC with ready still 0, the FSM SHALL go to GAP, pop the command, and push a response with rsp_rdata=32'hDEAD_DEAD and rsp_err=1.
REQ-022 Without APB_CMDQ_TIMEOUT_EN:
- REQ SHALL wait indefinitely for ready;
- no counter logic SHALL be synthesized;
- rsp_err SHALL be tied 0.

Verification
REQ-023 Read path: reset, push read addr 0x4, master returns rdata 0x1234 -> req high 1 cycle after accept; response {write=0, addr=0x4, rdata=0x1234, err=0}.
REQ-024 Write path: push write addr 0x8, data 0xA0000002 -> write=1, addr=0x8, wdata=0xA0000002 on the master side; response rdata=0, err=0.
REQ-025 Backpressure, DEPTH=4, rsp_ready=0, 8 pushes:
- 4 transfers complete, then req stays 0;
- after the remaining pushes the command FIFO holds 4 and cmd_ready=0;
- releasing rsp_ready drains all 8 responses in order.
REQ-026 Gap rule: 2 queued commands with ready asserted immediately -> req low exactly 1 cycle between transfers; ready pulsed during GAP is ignored.
REQ-027 Reset mid-transfer: rst asserted while req=1 -> req=0 immediately, rsp_valid=0, cmd_count=0; the next command completes normally.
REQ-028 Timeout, macro defined, TMO_CYC=16, ready never asserted -> req drops after 16 cycles; response rdata=0xDEADDEAD, err=1.

Source files
------------

// File: rtl/apb_cmd_queue.sv
// Command/response queue in front of an APB master: buffers {write,addr,wdata}
// commands, issues one at a time, returns responses in order. Watchdog: APB_CMDQ_TIMEOUT_EN.
module apb_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int TMO_CYC = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [31:0]              cmd_addr,
  input  logic [31:0]              cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [31:0]              rsp_addr,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic                     req,
  output logic                     write,
  output logic [31:0]              addr,
  output logic [31:0]              wdata,
  input  logic [31:0]              rdata,
  input  logic                     ready,
  output logic [$clog2(DEPTH):0]   cmd_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TMO_CYC < 1) begin : g_param_chk
    $error("apb_cmd_queue: DEPTH must be a power of 2 >= 2, TMO_CYC >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

  state_t        r_state;
  logic          r_live;
  logic          r_req, r_write;
  logic [31:0]   r_addr, r_wdata;

  logic [64:0]   r_cmd_mem [DEPTH];
  logic [AW-1:0] r_cmd_wp, r_cmd_rp;
  logic [CW-1:0] r_cmd_cnt;

  logic [64:0]   r_rsp_mem [DEPTH];
  logic [AW-1:0] r_rsp_wp, r_rsp_rp;
  logic [CW-1:0] r_rsp_cnt;

  logic          w_cmd_push, w_cmd_pop, w_rsp_pop, w_done, w_tmo, w_can_issue;
  logic [64:0]   w_cmd_head, w_rsp_head, w_rsp_din;

  // Response slot is reserved at issue: only one transfer is ever in flight,
  // and it is only started while the response FIFO has room for it.
  assign w_can_issue = (r_cmd_cnt != '0) && (r_rsp_cnt < CW'(DEPTH));
  assign w_done      = ready | w_tmo;
  assign w_cmd_push  = cmd_valid & cmd_ready;
  assign w_cmd_pop   = (r_state == S_REQ) & w_done;
  assign w_rsp_pop   = rsp_valid & rsp_ready;
  assign w_cmd_head  = r_cmd_mem[r_cmd_rp];
  assign w_rsp_head  = r_rsp_mem[r_rsp_rp];

  assign cmd_ready = r_live & (r_cmd_cnt < CW'(DEPTH));
  assign cmd_count = r_cmd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live    <= 1'b0;
      r_cmd_wp  <= '0;
      r_cmd_rp  <= '0;
      r_cmd_cnt <= '0;
      r_rsp_wp  <= '0;
      r_rsp_rp  <= '0;
      r_rsp_cnt <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_cmd_push) r_cmd_wp <= r_cmd_wp + 1'b1;
      if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + 1'b1;
      r_cmd_cnt <= r_cmd_cnt + CW'(w_cmd_push) - CW'(w_cmd_pop);
      if (w_cmd_pop)  r_rsp_wp <= r_rsp_wp + 1'b1;
      if (w_rsp_pop)  r_rsp_rp <= r_rsp_rp + 1'b1;
      r_rsp_cnt <= r_rsp_cnt + CW'(w_cmd_pop) - CW'(w_rsp_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_cmd_push) r_cmd_mem[r_cmd_wp] <= {cmd_write, cmd_addr, cmd_wdata};
    if (w_cmd_pop)  r_rsp_mem[r_rsp_wp] <= w_rsp_din;
  end

  // Head outputs are gated so an empty FIFO shows all-zero response fields.
  assign rsp_valid = (r_rsp_cnt != '0);
  assign rsp_write = rsp_valid & w_rsp_head[64];
  assign rsp_addr  = rsp_valid ? w_rsp_head[63:32] : 32'h0;
  assign rsp_rdata = rsp_valid ? w_rsp_head[31:0]  : 32'h0;

`ifdef APB_CMDQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] r_wdog;
  logic          r_err_mem [DEPTH];
  logic          w_tmo_hit;

  assign w_tmo     = (r_state == S_REQ) && (r_wdog == TW'(TMO_CYC - 1));
  assign w_tmo_hit = w_tmo & ~ready;
  assign w_rsp_din = {r_write, r_addr,
                      w_tmo_hit ? 32'hDEAD_DEAD : (r_write ? 32'h0 : rdata)};
  assign rsp_err   = rsp_valid & r_err_mem[r_rsp_rp];

  always_ff @(posedge clk) begin
    if (w_cmd_pop) r_err_mem[r_rsp_wp] <= w_tmo_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_wdog <= '0;
    else if (r_state != S_REQ)  r_wdog <= '0;
    else if (!ready)            r_wdog <= r_wdog + 1'b1;
  end
`else
  assign w_tmo     = 1'b0;
  assign w_rsp_din = {r_write, r_addr, r_write ? 32'h0 : rdata};
  assign rsp_err   = 1'b0;
`endif

  // GAP holds req low one cycle; pending work is picked up on GAP exit so
  // back-to-back transfers are separated by exactly one idle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE, S_GAP: begin
          if (w_can_issue) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            {r_write, r_addr, r_wdata} <= w_cmd_head;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (w_done) begin
            r_state <= S_GAP;
            r_req   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req   = r_req;
  assign write = r_write;
  assign addr  = r_addr;
  assign wdata = r_wdata;

endmodule

// File: tb/tb_apb_cmd_queue.sv
// Directed bench for apb_cmd_queue: vector table for single transfers plus
// hand sequences for backpressure, gap, reset-abort and (if enabled) timeout.
module tb_apb_cmd_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_addr, rsp_rdata;
  logic        req, write, ready;
  logic [31:0] addr, wdata, rdata, tb_rdata;
  logic [2:0]  cmd_count;
  logic        use_model;

  always #5 clk = ~clk;

  // Simple slave model for multi-transfer runs: read data derived from address.
  always_comb rdata = use_model ? (addr ^ 32'hFFFF_0000) : tb_rdata;

  apb_cmd_queue #(.DEPTH(4), .TMO_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .req(req), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .cmd_count(cmd_count)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[4];

  task automatic run_vec(input vec_t v, input string tag);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    chk({tag, ".cmd_ready"}, cmd_ready, 1);
    tick;
    cmd_valid = 1'b0;
    chk({tag, ".req_lat0"}, req, 0);
    chk({tag, ".count1"}, cmd_count, 1);
    tick;
    chk({tag, ".req"}, req, 1);
    chk({tag, ".write"}, write, v.wr);
    chk({tag, ".addr"}, addr, v.addr);
    chk({tag, ".wdata"}, wdata, v.wdata);
    ready = 1'b1; tb_rdata = v.mrd;
    tick;
    ready = 1'b0;
    chk({tag, ".req_off"}, req, 0);
    chk({tag, ".rsp_valid"}, rsp_valid, 1);
    chk({tag, ".rsp_write"}, rsp_write, v.wr);
    chk({tag, ".rsp_addr"}, rsp_addr, v.addr);
    chk({tag, ".rsp_rdata"}, rsp_rdata, v.exp_rd);
    chk({tag, ".rsp_err"}, rsp_err, 0);
    chk({tag, ".count0"}, cmd_count, 0);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk({tag, ".rsp_empty"}, rsp_valid, 0);
  endtask

  initial begin
    int w;
    int hi;
    vt[0] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0000_1234, 32'h0000_1234};
    vt[1] = '{1'b1, 32'h0000_0008, 32'hA000_0002, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[2] = '{1'b0, 32'hFFFF_FFFC, 32'h5555_5555, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vt[3] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1111_1111, 32'h0000_0000};

    rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 0; ready = 0; tb_rdata = 0; use_model = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.cmd_ready", cmd_ready, 0);
    chk("rst.req", req, 0);
    chk("rst.write", write, 0);
    chk("rst.addr", addr, 0);
    chk("rst.wdata", wdata, 0);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.rsp_write", rsp_write, 0);
    chk("rst.rsp_addr", rsp_addr, 0);
    chk("rst.rsp_rdata", rsp_rdata, 0);
    chk("rst.rsp_err", rsp_err, 0);
    chk("rst.cmd_count", cmd_count, 0);
    rst = 1'b0;
    #1;
    chk("rel.cmd_ready_pre", cmd_ready, 0);
    tick;
    chk("rel.cmd_ready_post", cmd_ready, 1);

    for (int i = 0; i < 4; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Backpressure: responses never consumed until all 8 commands are in.
    use_model = 1'b1; ready = 1'b1; rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h100 + 32'(i) * 4; cmd_wdata = 0;
      for (w = 0; w < 50 && !cmd_ready; w++) tick;
      if (!cmd_ready) chk($sformatf("bp.push%0d_wait", i), 0, 1);
      tick;
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk($sformatf("bp.req_hold%0d", i), req, 0);
    end
    chk("bp.cmd_count", cmd_count, 4);
    chk("bp.cmd_ready", cmd_ready, 0);
    chk("bp.rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      for (w = 0; w < 50 && !rsp_valid; w++) tick;
      chk($sformatf("bp.rsp%0d_addr", j), rsp_addr, 32'h100 + 32'(j) * 4);
      chk($sformatf("bp.rsp%0d_rdata", j), rsp_rdata, (32'h100 + 32'(j) * 4) ^ 32'hFFFF_0000);
      tick;
    end
    rsp_ready = 1'b0; ready = 1'b0; use_model = 1'b0;
    repeat (3) tick;
    chk("bp.drained_count", cmd_count, 0);
    chk("bp.drained_rsp", rsp_valid, 0);

    // Gap rule: two queued commands, ready held high throughout.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
    tick;
    cmd_addr = 32'h24;
    tick;
    cmd_valid = 1'b0;
    chk("gap.req_a", req, 1);
    chk("gap.addr_a", addr, 32'h20);
    ready = 1'b1; tb_rdata = 32'h11;
    tick;
    chk("gap.req_low", req, 0);
    chk("gap.count_mid", cmd_count, 1);
    tb_rdata = 32'h22;
    tick;
    chk("gap.req_b", req, 1);
    chk("gap.addr_b", addr, 32'h24);
    chk("gap.ready_ignored", cmd_count, 1);
    tick;
    ready = 1'b0;
    chk("gap.req_end", req, 0);
    chk("gap.count_end", cmd_count, 0);
    chk("gap.rsp0_addr", rsp_addr, 32'h20);
    chk("gap.rsp0_rdata", rsp_rdata, 32'h11);
    rsp_ready = 1'b1;
    tick;
    chk("gap.rsp1_addr", rsp_addr, 32'h24);
    chk("gap.rsp1_rdata", rsp_rdata, 32'h22);
    tick;
    rsp_ready = 1'b0;
    chk("gap.rsp_empty", rsp_valid, 0);

    // Reset during an active transfer abandons it.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
    tick;
    cmd_valid = 1'b0;
    tick;
    chk("rmid.req_before", req, 1);
    #2 rst = 1'b1;
    #1;
    chk("rmid.req", req, 0);
    chk("rmid.rsp_valid", rsp_valid, 0);
    chk("rmid.cmd_count", cmd_count, 0);
    chk("rmid.cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    tick;
    chk("rmid.cmd_ready_back", cmd_ready, 1);
    run_vec(vt[0], "rmid.next");

`ifdef APB_CMDQ_TIMEOUT_EN
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80;
    tick;
    cmd_valid = 1'b0;
    tick;
    hi = 0;
    for (w = 0; w < 100 && req; w++) begin
      hi++;
      tick;
    end
    chk("tmo.req_cycles", hi, 16);
    chk("tmo.rsp_valid", rsp_valid, 1);
    chk("tmo.rsp_addr", rsp_addr, 32'h80);
    chk("tmo.rsp_rdata", rsp_rdata, 32'hDEAD_DEAD);
    chk("tmo.rsp_err", rsp_err, 1);
    chk("tmo.cmd_count", cmd_count, 0);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
`else
    hi = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
